// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for a rate-1/2 K=3 convolutional encoder: clears it, feeds a frame MSB-first, registers symbols.
// Define CENC_TAIL_EN to append two zero tail bits that return the trellis to the zero state.
module conv_enc_frame_ctrl #(
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_LEN-1:0] in_data,
  input  logic                 abort,
  output logic                 enc_b,
  output logic                 enc_rst,
  input  logic [1:0]           enc_c,
  output logic [1:0]           out_sym,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 done,
  output logic                 busy
);

`ifdef CENC_TAIL_EN
  typedef enum logic [1:0] {IDLE, CLEAR, DATA, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR, DATA} state_t;
`endif

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           out_sym_q, out_sym_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 sym_valid, sym_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    enc_rst   = 1'b0;
    enc_b     = 1'b0;
    sym_valid = 1'b0;
    sym_last  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        enc_rst  = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        enc_rst = 1'b1;
        state_d = abort ? IDLE : DATA;
      end
      DATA: begin
        enc_b     = shreg_q[FRAME_LEN-1];
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        sym_valid = 1'b1;
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
`ifdef CENC_TAIL_EN
          cnt_d   = '0;
          state_d = TAIL;
`else
          sym_last = 1'b1;
          state_d  = IDLE;
`endif
        end
        if (abort) begin
          sym_valid = 1'b0;
          sym_last  = 1'b0;
          state_d   = IDLE;
        end
      end
`ifdef CENC_TAIL_EN
      TAIL: begin
        cnt_d     = cnt_q + CNT_W'(1);
        sym_valid = 1'b1;
        // cnt restarts at 0 on entry, so 1 marks the second tail bit
        if (cnt_q == CNT_W'(1)) begin
          sym_last = 1'b1;
          state_d  = IDLE;
        end
        if (abort) begin
          sym_valid = 1'b0;
          sym_last  = 1'b0;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    out_sym_d   = sym_valid ? enc_c : out_sym_q;
    out_valid_d = sym_valid;
    out_last_d  = sym_last;
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = out_valid_q & out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl with FRAME_LEN=4 and a behavioural conv_encoder model.
// Expected symbols are hand-computed; the tail-dependent count follows CENC_TAIL_EN.
module tb_conv_enc_frame_ctrl;
  localparam int FRAME_LEN = 4;
`ifdef CENC_TAIL_EN
  localparam int NSYM = 6;
`else
  localparam int NSYM = 4;
`endif
  // {c1,c0} per symbol, first symbol in the top bits
  localparam logic [11:0] EXP_1011 = {2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
  localparam logic [11:0] EXP_0000 = 12'h000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [FRAME_LEN-1:0] in_data;
  logic                 abort;
  logic                 enc_b;
  logic                 enc_rst;
  logic [1:0]           enc_c;
  logic [1:0]           out_sym;
  logic                 out_valid;
  logic                 out_last;
  logic                 done;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  logic d0 = 1'b0;
  logic d1 = 1'b0;

  conv_enc_frame_ctrl #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .abort    (abort),
    .enc_b    (enc_b),
    .enc_rst  (enc_rst),
    .enc_c    (enc_c),
    .out_sym  (out_sym),
    .out_valid(out_valid),
    .out_last (out_last),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // conv_encoder model: c0 = b^D0^D1, c1 = b^D1, synchronous clear
  always @(posedge clk) begin
    if (enc_rst) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      d0 <= enc_b;
      d1 <= d0;
    end
  end
  assign enc_c = {enc_b ^ d1, enc_b ^ d0 ^ d1};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_enc_rst"}, enc_rst, 1);
    chk({tag, "_enc_b"}, enc_b, 0);
    chk({tag, "_out_sym"}, out_sym, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic hs(input logic [FRAME_LEN-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk("hs_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
  endtask

  // Entered at handshake+1 (CLEAR); leaves one cycle after the out_last symbol.
  task automatic recv(input logic [11:0] exp, input bit noise, input bit chain,
                      input logic [FRAME_LEN-1:0] nd);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 1);
    chk("clr_enc_rst", enc_rst, 1);
    chk("clr_enc_b", enc_b, 0);
    chk("clr_ready", in_ready, 0);
    if (noise) begin
      in_valid = 1'b1;
      in_data  = FRAME_LEN'($urandom);
    end
    step;
    chk("lat_valid", out_valid, 0);
    chk("data_enc_rst", enc_rst, 0);
    if (noise) in_data = FRAME_LEN'($urandom);
    step;
    for (int i = 0; i < NSYM; i++) begin
      chk("sym", out_sym, exp[11-2*i -: 2]);
      chk("sym_valid", out_valid, 1);
      chk("sym_last", out_last, (i == NSYM - 1));
      chk("sym_done", done, (i == NSYM - 1));
      if (i == NSYM - 1) begin
        chk("last_ready", in_ready, 1);
        chk("last_busy", busy, 0);
        in_valid = chain;
        in_data  = nd;
      end else begin
        chk("mid_ready", in_ready, 0);
        if (noise) in_data = FRAME_LEN'($urandom);
      end
      step;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    step;
    chk_reset_vals("idle");

    // single frame
    hs(4'b1011);
    recv(EXP_1011, 1'b0, 1'b0, '0);
    chk("post_valid", out_valid, 0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    step;

    // back-to-back; the second frame's CLEAR must wipe the first frame's encoder state
    hs(4'b1011);
    recv(EXP_1011, 1'b0, 1'b1, 4'b0000);
    recv(EXP_0000, 1'b0, 1'b0, '0);
    chk("b2b_post_valid", out_valid, 0);
    step;

    // abort in the second DATA cycle
    hs(4'b1011);
    step;
    step;
    chk("abt_valid_before", out_valid, 1);
    chk("abt_sym_before", out_sym, 2'b11);
    abort = 1'b1;
    step;
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("abt_valid", out_valid, 0);
      chk("abt_done", done, 0);
      chk("abt_busy", busy, 0);
      chk("abt_enc_rst", enc_rst, 1);
      step;
    end
    abort = 1'b1;
    chk("abt_idle_ready", in_ready, 1);
    step;
    abort = 1'b0;
    chk("abt_idle_busy", busy, 0);
    hs(4'b1011);
    recv(EXP_1011, 1'b0, 1'b0, '0);
    step;

    // async reset late in the frame, asserted between edges
    hs(4'b1011);
    for (int i = 0; i < NSYM; i++) step;
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    step;
    chk_reset_vals("rel");

    // in_valid held with changing data while busy
    hs(4'b1011);
    recv(EXP_1011, 1'b1, 1'b0, '0);
    chk("noise_post_busy", busy, 0);
    chk("noise_post_valid", out_valid, 0);
    step;
    chk("noise_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
